// File: rtl/tmds_pkg.sv
// Shared TMDS alignment definitions: control-token constants, aligner state
// encoding and the control-token detector.
package tmds_pkg;

    localparam int TMDS_WIDTH = 10;

    localparam logic [TMDS_WIDTH-1:0] CTRL_TOKEN_0 = 10'b1101010100;
    localparam logic [TMDS_WIDTH-1:0] CTRL_TOKEN_1 = 10'b0010101011;
    localparam logic [TMDS_WIDTH-1:0] CTRL_TOKEN_2 = 10'b0101010100;
    localparam logic [TMDS_WIDTH-1:0] CTRL_TOKEN_3 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        SETTLE = 2'd2,
        LOCKED = 2'd3
    } align_state_e;

    function automatic logic is_ctrl_token(input logic [TMDS_WIDTH-1:0] word);
        logic hit;
        hit = (word == CTRL_TOKEN_0) || (word == CTRL_TOKEN_1) ||
              (word == CTRL_TOKEN_2) || (word == CTRL_TOKEN_3);
        return hit;
    endfunction

endpackage

// File: rtl/tmds_lane_aligner.sv
// One TMDS lane: registers the deserializer word, flags control tokens and runs
// the search/slip/settle/lock state machine that steers the deserializer bitslip.
module tmds_lane_aligner
    import tmds_pkg::*;
#(
    parameter int WIDTH         = TMDS_WIDTH,
    parameter int LOCK_RUN      = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int SLIP_SETTLE   = 4,
    parameter int LOSS_WINDOW   = 1048576
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_locked,
    input  logic [WIDTH-1:0] deser_word,
    output logic             bit_slip,
    output logic [WIDTH-1:0] data,
    output logic             token,
    output logic [3:0]       slip_count,
    output logic             ch_locked
);

    localparam int RUN_W  = $clog2(LOCK_RUN + 1);
    localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
    localparam int SET_W  = $clog2(SLIP_SETTLE + 1);
    localparam int LOSS_W = $clog2(LOSS_WINDOW + 1);

    localparam logic [RUN_W-1:0]  RUN_DONE    = RUN_W'(LOCK_RUN);
    localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SLIP_SETTLE - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST   = LOSS_W'(LOSS_WINDOW - 1);
    localparam logic [3:0]        SLIP_LAST   = 4'(WIDTH - 1);

    logic [WIDTH-1:0]  data_r;
    logic              token_r;
    logic              token_s;
    align_state_e      state_r;
    align_state_e      state_s;
    logic [RUN_W-1:0]  run_cnt_r;
    logic [RUN_W-1:0]  run_cnt_s;
    logic [WIN_W-1:0]  win_cnt_r;
    logic [WIN_W-1:0]  win_cnt_s;
    logic [SET_W-1:0]  settle_cnt_r;
    logic [SET_W-1:0]  settle_cnt_s;
    logic [LOSS_W-1:0] loss_cnt_r;
    logic [LOSS_W-1:0] loss_cnt_s;
    logic [3:0]        slip_cnt_r;
    logic [3:0]        slip_cnt_s;
    logic              bit_slip_r;
    logic              ch_locked_r;

    assign token_s = is_ctrl_token(deser_word);

    // Next-state and counter update; the FSM only ever looks at the registered token flag.
    always_comb begin
        state_s      = state_r;
        run_cnt_s    = run_cnt_r;
        win_cnt_s    = win_cnt_r;
        settle_cnt_s = settle_cnt_r;
        loss_cnt_s   = loss_cnt_r;
        slip_cnt_s   = slip_cnt_r;
        if (!clk_locked) begin
            // Upstream clocking not stable: park in SEARCH, never request a slip.
            state_s      = SEARCH;
            run_cnt_s    = '0;
            win_cnt_s    = '0;
            settle_cnt_s = '0;
            loss_cnt_s   = '0;
        end else begin
            case (state_r)
                SEARCH: begin
                    settle_cnt_s = '0;
                    loss_cnt_s   = '0;
                    if (run_cnt_r == RUN_DONE) begin
                        state_s   = LOCKED;
                        run_cnt_s = '0;
                        win_cnt_s = '0;
                    end else if (win_cnt_r == WIN_LAST) begin
                        state_s    = SLIP;
                        run_cnt_s  = '0;
                        win_cnt_s  = '0;
                        slip_cnt_s = (slip_cnt_r == SLIP_LAST) ? 4'd0 : slip_cnt_r + 4'd1;
                    end else begin
                        win_cnt_s = win_cnt_r + 1'b1;
                        run_cnt_s = token_r ? run_cnt_r + 1'b1 : '0;
                    end
                end
                SLIP: begin
                    state_s      = SETTLE;
                    settle_cnt_s = '0;
                end
                SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_s      = SEARCH;
                        settle_cnt_s = '0;
                        run_cnt_s    = '0;
                        win_cnt_s    = '0;
                    end else begin
                        settle_cnt_s = settle_cnt_r + 1'b1;
                    end
                end
                LOCKED: begin
                    if (token_r) begin
                        loss_cnt_s = '0;
                    end else if (loss_cnt_r == LOSS_LAST) begin
                        state_s    = SEARCH;
                        loss_cnt_s = '0;
                        run_cnt_s  = '0;
                        win_cnt_s  = '0;
                    end else begin
                        loss_cnt_s = loss_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_s      = SEARCH;
                    run_cnt_s    = '0;
                    win_cnt_s    = '0;
                    settle_cnt_s = '0;
                    loss_cnt_s   = '0;
                end
            endcase
        end
    end

    // Word/flag capture, FSM state, counters and the state-decoded outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r       <= '0;
            token_r      <= 1'b0;
            state_r      <= SEARCH;
            run_cnt_r    <= '0;
            win_cnt_r    <= '0;
            settle_cnt_r <= '0;
            loss_cnt_r   <= '0;
            slip_cnt_r   <= 4'd0;
            bit_slip_r   <= 1'b0;
            ch_locked_r  <= 1'b0;
        end else begin
            data_r       <= deser_word;
            token_r      <= token_s;
            state_r      <= state_s;
            run_cnt_r    <= run_cnt_s;
            win_cnt_r    <= win_cnt_s;
            settle_cnt_r <= settle_cnt_s;
            loss_cnt_r   <= loss_cnt_s;
            slip_cnt_r   <= slip_cnt_s;
            bit_slip_r   <= (state_s == SLIP);
            ch_locked_r  <= (state_s == LOCKED);
        end
    end

    assign bit_slip   = bit_slip_r;
    assign data       = data_r;
    assign token      = token_r;
    assign slip_count = slip_cnt_r;
    assign ch_locked  = ch_locked_r;

endmodule

// File: rtl/tmds_word_aligner.sv
// Word aligner for NUM_CH TMDS lanes behind the 1:10 deserializers; one lane
// aligner per channel plus the registered all-lanes-locked indication.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int WIDTH         = TMDS_WIDTH,
    parameter int LOCK_RUN      = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int SLIP_SETTLE   = 4,
    parameter int LOSS_WINDOW   = 1048576
) (
    input  logic                    clk_1x_in,
    input  logic                    reset_in,
    input  logic                    clk_locked,
    input  logic [NUM_CH*WIDTH-1:0] deser_data_in,
    output logic [NUM_CH-1:0]       bit_slip_out,
    output logic [NUM_CH*WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]       token_out,
    output logic [NUM_CH*4-1:0]     slip_count,
    output logic [NUM_CH-1:0]       ch_locked,
    output logic                    all_locked
);

    logic all_locked_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        tmds_lane_aligner #(
            .WIDTH         (WIDTH),
            .LOCK_RUN      (LOCK_RUN),
            .SEARCH_WINDOW (SEARCH_WINDOW),
            .SLIP_SETTLE   (SLIP_SETTLE),
            .LOSS_WINDOW   (LOSS_WINDOW)
        ) u_lane (
            .clk        (clk_1x_in),
            .reset      (reset_in),
            .clk_locked (clk_locked),
            .deser_word (deser_data_in[i*WIDTH +: WIDTH]),
            .bit_slip   (bit_slip_out[i]),
            .data       (data_out[i*WIDTH +: WIDTH]),
            .token      (token_out[i]),
            .slip_count (slip_count[i*4 +: 4]),
            .ch_locked  (ch_locked[i])
        );
    end

    // Link-level lock follows the per-lane lock flags by one cycle.
    always_ff @(posedge clk_1x_in) begin
        if (reset_in) begin
            all_locked_r <= 1'b0;
        end else begin
            all_locked_r <= &ch_locked;
        end
    end

    assign all_locked = all_locked_r;

endmodule
